// File: rtl/pd_dw_nr_timing.sv
// -----------------------------------------------------------------------------
// pd_dw_nr_timing
//
// Purpose:
//   Downlink NR symbol timing generator. For each bandwidth mode the sample
//   stream is antenna-interleaved N ways. This block walks antenna index,
//   point-in-symbol (CP included), symbol-in-slot and slot count. It also
//   produces symbol-start, last-point and slot-end strobes. The first symbol
//   of every half-subframe uses the long-CP length L; all others use S.
//
// Ports:
//   sys_clk      in   1        single clock domain
//   sys_rst_n    in   1        asynchronous active-low reset
//   i_sel        in   4        bandwidth mode, latched only while i_fram=1
//   i_fram       in   1        synchronous frame restart (level-sensitive)
//   o_valid      out  1        timing running
//   o_ant_idx    out  ANT_W    antenna slot 0..N-1
//   o_pnt_idx    out  PNT_W    point within the current symbol
//   o_symb_idx   out  4        symbol within the slot
//   o_slot_idx   out  SLOT_W   free-running slot counter
//   o_sym_start  out  1        first cycle of a symbol (point 0, antenna 0)
//   o_last       out  1        every cycle of the final point of a symbol
//   o_slot_end   out  1        final cycle of the final symbol of a slot
//
// Every output is a register. The strobes are decoded from the next-state
// counter values, so they line up with the counters they describe.
// ANT_W must be at least 2 so that the default 4-way row always fits.
// -----------------------------------------------------------------------------
module pd_dw_nr_timing #(
    parameter int ANT_W          = 5,
    parameter int PNT_W          = 13,
    parameter int SYMB_PER_SLOT  = 14,
    parameter int SLOT_W         = 5,
    parameter int SLOTS_PER_HALF = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [3:0]        i_sel,
    input  logic              i_fram,
    output logic              o_valid,
    output logic [ANT_W-1:0]  o_ant_idx,
    output logic [PNT_W-1:0]  o_pnt_idx,
    output logic [3:0]        o_symb_idx,
    output logic [SLOT_W-1:0] o_slot_idx,
    output logic              o_sym_start,
    output logic              o_last,
    output logic              o_slot_end
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Mode table rows: 0 = 32-way, 1 = 16-way, 2 = 8-way, 3 = 4-way (default).
    // Lengths are stored as (length - 1) so they compare directly with the
    // point counter at its wrap point.
    localparam int ROW_LOG2  [4] = '{5, 4, 3, 2};
    localparam int ROW_LONG  [4] = '{555, 1111, 2223, 4447};
    localparam int ROW_SHORT [4] = '{547, 1095, 2191, 4383};
    localparam logic [1:0] DEFAULT_ROW = 2'd3;
    localparam logic [3:0] SYMB_LAST   = 4'(SYMB_PER_SLOT - 1);

    logic [3:0]       row_fits;
    logic [ANT_W-1:0] row_ant_max   [4];
    logic [PNT_W-1:0] row_long_max  [4];
    logic [PNT_W-1:0] row_short_max [4];

    // A row is only usable when its interleave fits in the antenna index.
    // Rows that do not fit resolve to the default row in the selector below.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row
            assign row_fits[gi]      = (ROW_LOG2[gi] <= ANT_W);
            assign row_ant_max[gi]   = row_fits[gi] ? ANT_W'((1 << ROW_LOG2[gi]) - 1) : '0;
            assign row_long_max[gi]  = PNT_W'(ROW_LONG[gi]);
            assign row_short_max[gi] = PNT_W'(ROW_SHORT[gi]);
        end
    endgenerate

    // Registered state
    state_t           state_reg,     state_next;
    logic [ANT_W-1:0] ant_max_reg,   ant_max_next;
    logic [PNT_W-1:0] long_max_reg,  long_max_next;
    logic [PNT_W-1:0] short_max_reg, short_max_next;
    logic [ANT_W-1:0] ant_reg,       ant_next;
    logic [PNT_W-1:0] pnt_reg,       pnt_next;
    logic [3:0]       symb_reg,      symb_next;
    logic [SLOT_W-1:0] slot_reg,     slot_next;
    logic             valid_reg,     valid_next;
    logic             sym_start_reg, sym_start_next;
    logic             last_reg,      last_next;
    logic             slot_end_reg,  slot_end_next;

    logic [1:0]       sel_row;
    logic [PNT_W-1:0] cur_len_max;
    logic [PNT_W-1:0] nxt_len_max;
    logic             run_next;

    // Long-CP symbol: symbol 0 of the first slot of each half-subframe.
    function automatic logic [PNT_W-1:0] sym_len_max(
        input logic [3:0]        symb,
        input logic [SLOT_W-1:0] slot,
        input logic [PNT_W-1:0]  lmax,
        input logic [PNT_W-1:0]  smax
    );
        if ((symb == 4'd0) && ((32'(slot) % 32'(SLOTS_PER_HALF)) == 32'd0)) begin
            return lmax;
        end
        return smax;
    endfunction

    // Bandwidth code to table row
    always_comb begin
        sel_row = DEFAULT_ROW;
        case (i_sel)
            4'h1:             sel_row = 2'd0;
            4'h2, 4'h3:       sel_row = 2'd1;
            4'h4, 4'h5, 4'h6: sel_row = 2'd2;
            default:          sel_row = DEFAULT_ROW;
        endcase
        if (!row_fits[sel_row]) begin
            sel_row = DEFAULT_ROW;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        state_next     = state_reg;
        ant_max_next   = ant_max_reg;
        long_max_next  = long_max_reg;
        short_max_next = short_max_reg;
        ant_next       = ant_reg;
        pnt_next       = pnt_reg;
        symb_next      = symb_reg;
        slot_next      = slot_reg;
        cur_len_max    = sym_len_max(symb_reg, slot_reg, long_max_reg, short_max_reg);

        if (i_fram) begin
            // Restart has priority over every wrap and over the IDLE hold.
            state_next     = RUN;
            ant_max_next   = row_ant_max[sel_row];
            long_max_next  = row_long_max[sel_row];
            short_max_next = row_short_max[sel_row];
            ant_next       = '0;
            pnt_next       = '0;
            symb_next      = 4'd0;
            slot_next      = '0;
        end else if (state_reg == RUN) begin
            if (ant_reg == ant_max_reg) begin
                ant_next = '0;
                if (pnt_reg == cur_len_max) begin
                    pnt_next = '0;
                    if (symb_reg == SYMB_LAST) begin
                        symb_next = 4'd0;
                        slot_next = slot_reg + 1'b1;
                    end else begin
                        symb_next = symb_reg + 4'd1;
                    end
                end else begin
                    pnt_next = pnt_reg + 1'b1;
                end
            end else begin
                ant_next = ant_reg + 1'b1;
            end
        end

        // Strobes describe the counter values being loaded this edge.
        nxt_len_max    = sym_len_max(symb_next, slot_next, long_max_next, short_max_next);
        run_next       = (state_next == RUN);
        valid_next     = run_next;
        sym_start_next = run_next && (ant_next == '0) && (pnt_next == '0);
        last_next      = run_next && (pnt_next == nxt_len_max);
        slot_end_next  = last_next && (ant_next == ant_max_next) && (symb_next == SYMB_LAST);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg     <= IDLE;
            ant_max_reg   <= row_ant_max[DEFAULT_ROW];
            long_max_reg  <= row_long_max[DEFAULT_ROW];
            short_max_reg <= row_short_max[DEFAULT_ROW];
            ant_reg       <= '0;
            pnt_reg       <= '0;
            symb_reg      <= 4'd0;
            slot_reg      <= '0;
            valid_reg     <= 1'b0;
            sym_start_reg <= 1'b0;
            last_reg      <= 1'b0;
            slot_end_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ant_max_reg   <= ant_max_next;
            long_max_reg  <= long_max_next;
            short_max_reg <= short_max_next;
            ant_reg       <= ant_next;
            pnt_reg       <= pnt_next;
            symb_reg      <= symb_next;
            slot_reg      <= slot_next;
            valid_reg     <= valid_next;
            sym_start_reg <= sym_start_next;
            last_reg      <= last_next;
            slot_end_reg  <= slot_end_next;
        end
    end

    assign o_valid     = valid_reg;
    assign o_ant_idx   = ant_reg;
    assign o_pnt_idx   = pnt_reg;
    assign o_symb_idx  = symb_reg;
    assign o_slot_idx  = slot_reg;
    assign o_sym_start = sym_start_reg;
    assign o_last      = last_reg;
    assign o_slot_end  = slot_end_reg;

endmodule

// File: tb/tb_pd_dw_nr_timing.sv
// -----------------------------------------------------------------------------
// tb_pd_dw_nr_timing
//
// Directed bench for pd_dw_nr_timing. The main instance uses two symbols per
// slot and two slots per half-subframe, so long/short symbol selection and the
// slot wrap show up within a short run. A second instance with a 3-bit
// antenna index shows wide modes falling back to the 4-way default row.
// Cycle k means the outputs k clock edges after the edge that sampled i_fram.
// -----------------------------------------------------------------------------
module tb_pd_dw_nr_timing;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [3:0]  i_sel;
    logic        i_fram;

    logic        o_valid;
    logic [4:0]  o_ant_idx;
    logic [12:0] o_pnt_idx;
    logic [3:0]  o_symb_idx;
    logic [4:0]  o_slot_idx;
    logic        o_sym_start;
    logic        o_last;
    logic        o_slot_end;

    logic        s_valid;
    logic [2:0]  s_ant_idx;
    logic [12:0] s_pnt_idx;
    logic [3:0]  s_symb_idx;
    logic [4:0]  s_slot_idx;
    logic        s_sym_start;
    logic        s_last;
    logic        s_slot_end;

    int n_cmp;
    int n_fail;

    pd_dw_nr_timing #(
        .ANT_W(5), .PNT_W(13), .SYMB_PER_SLOT(2), .SLOT_W(5), .SLOTS_PER_HALF(2)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .i_sel(i_sel), .i_fram(i_fram),
        .o_valid(o_valid), .o_ant_idx(o_ant_idx), .o_pnt_idx(o_pnt_idx),
        .o_symb_idx(o_symb_idx), .o_slot_idx(o_slot_idx), .o_sym_start(o_sym_start),
        .o_last(o_last), .o_slot_end(o_slot_end)
    );

    pd_dw_nr_timing #(
        .ANT_W(3), .PNT_W(13), .SYMB_PER_SLOT(2), .SLOT_W(5), .SLOTS_PER_HALF(2)
    ) dut_small (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .i_sel(i_sel), .i_fram(i_fram),
        .o_valid(s_valid), .o_ant_idx(s_ant_idx), .o_pnt_idx(s_pnt_idx),
        .o_symb_idx(s_symb_idx), .o_slot_idx(s_slot_idx), .o_sym_start(s_sym_start),
        .o_last(s_last), .o_slot_end(s_slot_end)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One-cycle restart; returns with cycle 0 visible and i_fram low.
    task automatic fram_pulse(input logic [3:0] sel);
        i_sel  = sel;
        i_fram = 1'b1;
        tick();
        i_fram = 1'b0;
    endtask

    int first_last, first_last_s1, last_cnt0, last_cnt1;
    int ss_cnt, ss1, ss2, ss3, se_cnt, se1, valid_drops, ss_bad;
    logic [31:0] ant_k4, s_ant_k4, s_pnt_k4, ant_k16, pnt_k16;
    logic [31:0] pnt_k17776, symb_k17792, slot_k35328, symb_k35328;

    initial begin
        n_cmp = 0; n_fail = 0;
        first_last = -1; first_last_s1 = -1; last_cnt0 = 0; last_cnt1 = 0;
        ss_cnt = 0; ss1 = -1; ss2 = -1; ss3 = -1; se_cnt = 0; se1 = -1;
        valid_drops = 0; ss_bad = 0;
        ant_k4 = '0; s_ant_k4 = '0; s_pnt_k4 = '0; ant_k16 = '0; pnt_k16 = '0;
        pnt_k17776 = '0; symb_k17792 = '0; slot_k35328 = '0; symb_k35328 = '0;

        // Reset state
        sys_rst_n = 1'b0; i_fram = 1'b0; i_sel = 4'h2;
        repeat (3) tick();
        check("rst_flags", {28'd0, o_valid, o_sym_start, o_last, o_slot_end}, 32'd0);
        check("rst_counters", {5'd0, o_ant_idx, o_pnt_idx, o_symb_idx, o_slot_idx}, 32'd0);

        // IDLE ignores i_sel
        sys_rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            i_sel = 4'(i);
            tick();
        end
        check("idle_flags", {28'd0, o_valid, o_sym_start, o_last, o_slot_end}, 32'd0);
        check("idle_counters", {5'd0, o_ant_idx, o_pnt_idx, o_symb_idx, o_slot_idx}, 32'd0);

        // Mode 2: N=16, L=1112, S=1096
        fram_pulse(4'h2);
        check("m2_c0_valid", 32'(o_valid), 32'd1);
        check("m2_c0_sym_start", 32'(o_sym_start), 32'd1);
        check("m2_c0_last", 32'(o_last), 32'd0);
        check("m2_c0_counters", {5'd0, o_ant_idx, o_pnt_idx, o_symb_idx, o_slot_idx}, 32'd0);

        for (int k = 1; k <= 52864; k++) begin
            tick();
            if (!o_valid) valid_drops++;
            if (o_sym_start !== ((o_ant_idx == '0) && (o_pnt_idx == '0))) ss_bad++;
            if (o_last) begin
                if (first_last < 0) first_last = k;
                if (k < 17792) last_cnt0++;
                else if (k < 35328) last_cnt1++;
                else if (first_last_s1 < 0) first_last_s1 = k;
            end
            if (o_sym_start) begin
                ss_cnt++;
                if (ss_cnt == 1) ss1 = k;
                else if (ss_cnt == 2) ss2 = k;
                else if (ss_cnt == 3) ss3 = k;
            end
            if (o_slot_end) begin
                se_cnt++;
                if (se_cnt == 1) se1 = k;
            end
            if (k == 4) begin
                ant_k4   = 32'(o_ant_idx);
                s_ant_k4 = 32'(s_ant_idx);
                s_pnt_k4 = 32'(s_pnt_idx);
            end
            if (k == 16) begin
                ant_k16 = 32'(o_ant_idx);
                pnt_k16 = 32'(o_pnt_idx);
            end
            if (k == 17776) pnt_k17776 = 32'(o_pnt_idx);
            if (k == 17792) symb_k17792 = 32'(o_symb_idx);
            if (k == 35328) begin
                slot_k35328 = 32'(o_slot_idx);
                symb_k35328 = 32'(o_symb_idx);
            end
        end
        check("m2_valid_drops", 32'(valid_drops), 32'd0);
        check("m2_sym_start_decode", 32'(ss_bad), 32'd0);
        check("m2_ant_k4", ant_k4, 32'd4);
        check("m2_ant_wrap_k16", ant_k16, 32'd0);
        check("m2_pnt_k16", pnt_k16, 32'd1);
        check("m2_first_last", 32'(first_last), 32'd17776);
        check("m2_pnt_at_first_last", pnt_k17776, 32'd1111);
        check("m2_last_len_sym0", 32'(last_cnt0), 32'd16);
        check("m2_second_sym_start", 32'(ss1), 32'd17792);
        check("m2_symb_at_17792", symb_k17792, 32'd1);
        check("m2_last_len_sym1", 32'(last_cnt1), 32'd16);
        check("m2_slot_end_cycle", 32'(se1), 32'd35327);
        check("m2_slot_end_count", 32'(se_cnt), 32'd1);
        check("m2_slot1_start", 32'(ss2), 32'd35328);
        check("m2_slot_idx_1", slot_k35328, 32'd1);
        check("m2_symb_wrap", symb_k35328, 32'd0);
        check("m2_slot1_sym0_short_last", 32'(first_last_s1), 32'd52848);
        check("m2_slot1_sym1_start", 32'(ss3), 32'd52864);
        check("m2_ss_count", 32'(ss_cnt), 32'd3);
        check("small_default_ant_k4", s_ant_k4, 32'd0);
        check("small_default_pnt_k4", s_pnt_k4, 32'd1);

        // Abort mid-symbol with a new mode
        repeat (40) tick();
        check("pre_abort_symb", 32'(o_symb_idx), 32'd1);
        check("pre_abort_ant", 32'(o_ant_idx), 32'd8);
        fram_pulse(4'h8);
        check("abort_counters", {5'd0, o_ant_idx, o_pnt_idx, o_symb_idx, o_slot_idx}, 32'd0);
        check("abort_flags", {28'd0, o_valid, o_sym_start, o_last, o_slot_end}, 32'b1100);

        // i_sel change without i_fram keeps N=4
        i_sel = 4'h2;
        repeat (3) tick();
        check("m8_ant_k3", 32'(o_ant_idx), 32'd3);
        tick();
        check("m8_ant_wrap_k4", 32'(o_ant_idx), 32'd0);
        check("m8_pnt_k4", 32'(o_pnt_idx), 32'd1);

        // Next restart picks up N=16
        fram_pulse(4'h2);
        repeat (4) tick();
        check("m2b_ant_k4", 32'(o_ant_idx), 32'd4);
        repeat (12) tick();
        check("m2b_ant_wrap_k16", 32'(o_ant_idx), 32'd0);
        check("m2b_pnt_k16", 32'(o_pnt_idx), 32'd1);

        // Mode 1 with i_fram held: counters pinned at 0
        i_sel = 4'h1; i_fram = 1'b1;
        tick(); tick();
        check("hold_counters", {5'd0, o_ant_idx, o_pnt_idx, o_symb_idx, o_slot_idx}, 32'd0);
        check("hold_flags", {28'd0, o_valid, o_sym_start, o_last, o_slot_end}, 32'b1100);
        i_fram = 1'b0;
        tick();
        check("m1_ant_k1", 32'(o_ant_idx), 32'd1);
        repeat (30) tick();
        check("m1_ant_k31", 32'(o_ant_idx), 32'd31);
        tick();
        check("m1_ant_wrap_k32", 32'(o_ant_idx), 32'd0);
        check("m1_pnt_k32", 32'(o_pnt_idx), 32'd1);
        check("small_m1_default_pnt_k32", 32'(s_pnt_idx), 32'd8);

        // Mode 4: 8-way fits the 3-bit instance
        fram_pulse(4'h4);
        repeat (7) tick();
        check("small_m4_ant_k7", 32'(s_ant_idx), 32'd7);
        tick();
        check("small_m4_ant_wrap_k8", 32'(s_ant_idx), 32'd0);
        check("m4_ant_k8", 32'(o_ant_idx), 32'd0);
        check("m4_pnt_k8", 32'(o_pnt_idx), 32'd1);

        // Asynchronous reset mid-run
        repeat (5) tick();
        #2 sys_rst_n = 1'b0;
        #1;
        check("async_rst_flags", {28'd0, o_valid, o_sym_start, o_last, o_slot_end}, 32'd0);
        check("async_rst_counters", {5'd0, o_ant_idx, o_pnt_idx, o_symb_idx, o_slot_idx}, 32'd0);
        tick();
        sys_rst_n = 1'b1;
        i_sel = 4'hF;
        repeat (3) tick();
        check("post_rst_idle_valid", 32'(o_valid), 32'd0);

        // Unlisted code 4'hF: default 4-way row
        fram_pulse(4'hF);
        check("mf_c0_valid", 32'(o_valid), 32'd1);
        repeat (3) tick();
        check("mf_ant_k3", 32'(o_ant_idx), 32'd3);
        tick();
        check("mf_ant_wrap_k4", 32'(o_ant_idx), 32'd0);
        check("mf_pnt_k4", 32'(o_pnt_idx), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pd_dw_nr_timing.md
PD_DW_NR_TIMING -- requirements
Module: pd_dw_nr_timing

Interface
REQ-001 SHALL have parameter ANT_W, default 5, width of antenna index (max interleave 2^ANT_W).
REQ-002 SHALL have parameter PNT_W, default 13, width of symbol point counter.
REQ-003 SHALL have parameter SYMB_PER_SLOT, default 14, symbols per slot.
REQ-004 SHALL have parameter SLOT_W, default 5; SLOTS_PER_HALF, default 1 (slots per half-subframe, long-CP period).
REQ-005 SHALL have port sys_clk  in  1  491.52 MHz clock, single clock domain.
REQ-006 SHALL have port sys_rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port i_sel  in  4  bandwidth mode, sampled only while i_fram=1.
REQ-008 SHALL have port i_fram  in  1  synchronous frame restart, level-sensitive.
REQ-009 SHALL have port o_valid  out  1  timing running.
REQ-010 SHALL have port o_ant_idx  out  ANT_W  current antenna slot.
REQ-011 SHALL have port o_pnt_idx  out  PNT_W  current point in symbol (CP included).
REQ-012 SHALL have port o_symb_idx  out  4  symbol in slot; o_slot_idx  out  SLOT_W  slot count.
REQ-013 SHALL have ports o_sym_start, o_last, o_slot_end  out  1 each, strobes per REQ-020..022.

Function
REQ-014 Mode table latched on i_fram=1 (interleave N / long-symbol length L / normal length S, points): 4'h1: 32/556/548; 4'h2,4'h3: 16/1112/1096; 4'h4..4'h6: 8/2224/2192; 4'h8..4'hA and all other codes: 4/4448/4384.
REQ-015 Any code whose N exceeds 2^ANT_W SHALL map to the default 4/4448/4384 row.
REQ-016 Two-state FSM IDLE/RUN: reset -> IDLE; i_fram=1 -> RUN from any state; RUN never returns to IDLE except by reset.
REQ-017 While i_fram=1, all counters SHALL be held at 0 and o_valid=1; the cycle after i_fram falls is ant 1 of point 0.
REQ-018 o_ant_idx SHALL count 0..N-1 every cycle in RUN and wrap; o_pnt_idx SHALL advance only on ant wrap.
REQ-019 Symbol length SHALL be L when o_symb_idx=0 and o_slot_idx mod SLOTS_PER_HALF = 0, else S; o_pnt_idx wraps at length-1; o_symb_idx wraps at SYMB_PER_SLOT-1 and increments o_slot_idx (free-running, wraps at 2^SLOT_W).
REQ-020 o_sym_start SHALL be 1 exactly when o_pnt_idx=0 and o_ant_idx=0 in RUN.
REQ-021 o_last SHALL be 1 for all N cycles of the final point of every symbol, 0 otherwise.
REQ-022 o_slot_end SHALL be a one-cycle pulse on the final cycle (last point, ant N-1) of symbol SYMB_PER_SLOT-1.
REQ-023 All outputs SHALL be registered; simultaneous i_fram and any wrap: i_fram wins.
REQ-024 i_sel changes while i_fram=0 SHALL have no effect until the next i_fram.
REQ-025 Cycles per slot SHALL be N*(L+(SYMB_PER_SLOT-1)*S); 245760 for every table row with default parameters.

Reset
REQ-026 On sys_rst_n=0, asynchronously: FSM=IDLE, latched mode = default row, all counters 0, o_valid=0, all strobes 0.
REQ-027 In IDLE, outputs SHALL stay at reset values regardless of i_sel; reset mid-RUN SHALL abort immediately, no strobe completed.

Verification
REQ-028 Reset, i_sel=4'h2, one-cycle i_fram -> o_sym_start at that cycle; first o_last after 1111*16 further cycles, lasting 16 cycles; second o_sym_start 17792 cycles after first.
REQ-029 i_sel=4'h8 run two slots -> symbol 0 spans 17792 cycles, symbols 1..13 span 17536 each, o_slot_end pulses at cycles 245759 and 491519 after i_fram, o_slot_idx 0->1->2.
REQ-030 SLOTS_PER_HALF=2, i_sel=4'h4 -> symbol 0 of slot 0 length 2224 points, symbol 0 of slot 1 length 2192, slot 2 back to 2224.
REQ-031 i_fram reasserted mid-symbol 5 -> next cycle counters 0, o_sym_start=1, no o_last/o_slot_end from aborted symbol.
REQ-032 i_sel changed 4'h8->4'h2 without i_fram -> timing unchanged (N=4); after next i_fram, N=16.
REQ-033 sys_rst_n pulsed low mid-RUN -> outputs 0 asynchronously; after release, o_valid stays 0 until i_fram; i_sel=4'hF -> default row 4/4448/4384.
